// File: rtl/full_add.sv
// ---------------------------------------------------------------------------
// full_add
//
// Single-bit full adder. The combinational path (sum/cout) is pure logic and
// needs no clock. A registered copy of the result (sum_q/cout_q) is captured
// on rising clk when en is high. valid_q marks a cycle whose registered
// result was captured on the previous edge.
//
// Optional feature: define FULL_ADD_STATS_EN to build saturating statistics
// counters (op_cnt: captures, carry_cnt: captures with carry-out set).
// Without the macro both counter outputs are tied to zero and no counter
// flops exist.
//
// Parameters:
//   COUNT_W   width of the statistics counters (1..32), default 16
//
// Ports:
//   clk        in   block clock, rising-edge active
//   rst        in   asynchronous, active-high reset
//   a, b, cin  in   addends and carry-in
//   en         in   capture enable for the registered stage
//   sum, cout  out  combinational sum / carry-out
//   sum_q      out  registered sum
//   cout_q     out  registered carry-out
//   valid_q    out  high while sum_q/cout_q hold a freshly captured result
//   carry_cnt  out  captures with carry-out set (statistics build only)
//   op_cnt     out  total captures (statistics build only)
// ---------------------------------------------------------------------------
module full_add #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               a,
    input  logic               b,
    input  logic               cin,
    input  logic               en,
    output logic               sum,
    output logic               cout,
    output logic               sum_q,
    output logic               cout_q,
    output logic               valid_q,
    output logic [COUNT_W-1:0] carry_cnt,
    output logic [COUNT_W-1:0] op_cnt
);

    // Plain operators keep X propagation intact; no masking of unknowns.
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

    logic sum_reg;
    logic cout_reg;
    logic valid_reg;

    // en is only sampled when rst is low, so reset always wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_reg   <= 1'b0;
            cout_reg  <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= en;
            if (en) begin
                sum_reg  <= sum;
                cout_reg <= cout;
            end
        end
    end

    assign sum_q   = sum_reg;
    assign cout_q  = cout_reg;
    assign valid_q = valid_reg;

`ifdef FULL_ADD_STATS_EN
    logic [COUNT_W-1:0] op_cnt_reg;
    logic [COUNT_W-1:0] carry_cnt_reg;

    // Counters stop at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_cnt_reg    <= '0;
            carry_cnt_reg <= '0;
        end else if (en) begin
            if (op_cnt_reg != {COUNT_W{1'b1}})
                op_cnt_reg <= op_cnt_reg + 1'b1;
            if (cout && (carry_cnt_reg != {COUNT_W{1'b1}}))
                carry_cnt_reg <= carry_cnt_reg + 1'b1;
        end
    end

    assign op_cnt    = op_cnt_reg;
    assign carry_cnt = carry_cnt_reg;
`else
    assign op_cnt    = '0;
    assign carry_cnt = '0;
`endif

endmodule

// File: tb/tb_full_add.sv
// ---------------------------------------------------------------------------
// tb_full_add
//
// Directed bench for full_add. A truth-table array drives the combinational
// check with the clock stopped; hand-written sequences cover registered
// capture, hold, asynchronous reset, reset/enable overlap and the
// statistics counters (expected values depend on FULL_ADD_STATS_EN).
// ---------------------------------------------------------------------------
module tb_full_add;

    localparam int CW = 2;

    logic          clk;
    logic          rst;
    logic          a;
    logic          b;
    logic          cin;
    logic          en;
    logic          sum;
    logic          cout;
    logic          sum_q;
    logic          cout_q;
    logic          valid_q;
    logic [CW-1:0] carry_cnt;
    logic [CW-1:0] op_cnt;

    int n_tests;
    int n_fail;
    bit clk_run;

    full_add #(.COUNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .en        (en),
        .sum       (sum),
        .cout      (cout),
        .sum_q     (sum_q),
        .cout_q    (cout_q),
        .valid_q   (valid_q),
        .carry_cnt (carry_cnt),
        .op_cnt    (op_cnt)
    );

    // Clock only toggles once clk_run is set, so the combinational check
    // runs with no clock at all.
    initial clk = 1'b0;
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    typedef struct {
        logic [2:0] abc;
        logic       s;
        logic       c;
    } vec_t;

    vec_t tt[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_regs(input string tag, input logic s, input logic c, input logic v);
        chk({tag, ".sum_q"}, {31'b0, sum_q}, {31'b0, s});
        chk({tag, ".cout_q"}, {31'b0, cout_q}, {31'b0, c});
        chk({tag, ".valid_q"}, {31'b0, valid_q}, {31'b0, v});
    endtask

    function automatic logic [31:0] exp_cnt(input int k);
`ifdef FULL_ADD_STATS_EN
        return (k > 3) ? 32'd3 : 32'(k);
`else
        return 32'd0 + 32'(k - k);
`endif
    endfunction

    initial begin
        n_tests = 0;
        n_fail  = 0;
        clk_run = 1'b0;

        tt[0] = '{3'b000, 1'b0, 1'b0};
        tt[1] = '{3'b001, 1'b1, 1'b0};
        tt[2] = '{3'b010, 1'b1, 1'b0};
        tt[3] = '{3'b011, 1'b0, 1'b1};
        tt[4] = '{3'b100, 1'b1, 1'b0};
        tt[5] = '{3'b101, 1'b0, 1'b1};
        tt[6] = '{3'b110, 1'b0, 1'b1};
        tt[7] = '{3'b111, 1'b1, 1'b1};

        // Asynchronous reset with no clock edge at all.
        rst = 1'b1; en = 1'b1; a = 1'b0; b = 1'b0; cin = 1'b0;
        #1;
        chk_regs("reset", 1'b0, 1'b0, 1'b0);
        chk("reset.op_cnt", 32'(op_cnt), 32'd0);
        chk("reset.carry_cnt", 32'(carry_cnt), 32'd0);

        // Exhaustive combinational check, clock stopped.
        for (int i = 0; i < 8; i++) begin
            {a, b, cin} = tt[i].abc;
            #1;
            chk($sformatf("comb%0d.sum", i), {31'b0, sum}, {31'b0, tt[i].s});
            chk($sformatf("comb%0d.cout", i), {31'b0, cout}, {31'b0, tt[i].c});
            #4;
        end

        // Start clock, release reset between edges.
        en = 1'b0;
        clk_run = 1'b1;
        tick();
        rst = 1'b0;

        // Capture 011, then hold with en=0.
        en = 1'b1; {a, b, cin} = 3'b011;
        tick();
        chk_regs("cap011", 1'b0, 1'b1, 1'b1);
        en = 1'b0; {a, b, cin} = 3'b100;
        tick();
        chk_regs("hold", 1'b0, 1'b1, 1'b0);

        // Capture 111, then async reset between edges.
        en = 1'b1; {a, b, cin} = 3'b111;
        tick();
        chk_regs("cap111", 1'b1, 1'b1, 1'b1);
        en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_regs("async_rst", 1'b0, 1'b0, 1'b0);
        chk("async_rst.sum", {31'b0, sum}, 32'd1);
        chk("async_rst.cout", {31'b0, cout}, 32'd1);

        // Reset held with en=1 across three edges.
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_regs($sformatf("overlap%0d", i), 1'b0, 1'b0, 1'b0);
        end
        rst = 1'b0;
        tick();
        chk_regs("first_cap", 1'b1, 1'b1, 1'b1);

        // Statistics: clear, then five captures of 111.
        en = 1'b0;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        chk("stats_clr.op_cnt", 32'(op_cnt), 32'd0);
        en = 1'b1; {a, b, cin} = 3'b111;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("stats%0d.op_cnt", k), 32'(op_cnt), exp_cnt(k));
            chk($sformatf("stats%0d.carry_cnt", k), 32'(carry_cnt), exp_cnt(k));
        end
        // A non-carrying capture moves op_cnt only (already saturated here).
        {a, b, cin} = 3'b001;
        tick();
        chk("stats_nc.op_cnt", 32'(op_cnt), exp_cnt(6));
        chk("stats_nc.carry_cnt", 32'(carry_cnt), exp_cnt(5));
        en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("stats_rst.op_cnt", 32'(op_cnt), 32'd0);
        chk("stats_rst.carry_cnt", 32'(carry_cnt), 32'd0);

        // Partial count: one carry and one non-carry capture after reset.
        rst = 1'b0;
        tick();
        en = 1'b1; {a, b, cin} = 3'b110;
        tick();
        {a, b, cin} = 3'b100;
        tick();
        chk("stats_mix.op_cnt", 32'(op_cnt), exp_cnt(2));
        chk("stats_mix.carry_cnt", 32'(carry_cnt), exp_cnt(1));
        chk_regs("cap100", 1'b1, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
